// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake, registered result and branch decision.
// Optional macro ALU_EXEC_FAST_SHIFT_EN selects a single-cycle barrel shifter instead of the iterative one.
module alu_exec_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  branch_taken
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned AW  = SHW + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BLT = 4'b1001;
  localparam logic [3:0] OP_BGE = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;
  localparam logic [3:0] OP_SLL = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  branch_q, branch_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]        rem_q, rem_d;
  logic [3:0]            sop_q, sop_d;

  logic                  accept;
  logic [SHW-1:0]        shamt;
  logic                  is_shift;
  logic                  start_shift;
  logic                  lt_s;
  logic                  eq;
  logic [DATA_WIDTH-1:0] one_res;
  logic                  one_br;
  logic [AW-1:0]         step_amt;
  logic [DATA_WIDTH-1:0] step_val;

  assign in_ready  = ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready)) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = branch_q;

  assign shamt    = operand_b[SHW-1:0];
  assign is_shift = (operation == OP_SRL) | (operation == OP_SRA) | (operation == OP_SLL);
  assign lt_s     = $signed(operand_a) < $signed(operand_b);
  assign eq       = (operand_a == operand_b);

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = is_shift & (shamt != '0);
`endif

  // Single-cycle result; in iterative mode shifts only land here when shamt is zero.
  always_comb begin
    one_res = '0;
    one_br  = 1'b0;
    case (operation)
      OP_AND: one_res = operand_a & operand_b;
      OP_OR:  one_res = operand_a | operand_b;
      OP_ADD: one_res = operand_a + operand_b;
      OP_XOR: one_res = operand_a ^ operand_b;
      OP_SUB: one_res = operand_a - operand_b;
      OP_SLT: one_res = DATA_WIDTH'(lt_s);
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SRL: one_res = operand_a >> shamt;
      OP_SRA: one_res = DATA_WIDTH'($signed(operand_a) >>> shamt);
      OP_SLL: one_res = operand_a << shamt;
`else
      OP_SRL: one_res = operand_a;
      OP_SRA: one_res = operand_a;
      OP_SLL: one_res = operand_a;
`endif
      OP_BEQ: one_br  = eq;
      OP_BLT: one_br  = lt_s;
      OP_BGE: one_br  = ~lt_s;
      OP_BNE: one_br  = ~eq;
      default: begin
        one_res = '0;
        one_br  = 1'b0;
      end
    endcase
  end

  // One iterative step: retire min(remaining, SHIFT_STEP) bits.
  always_comb begin
    step_amt = ({1'b0, rem_q} > AW'(SHIFT_STEP)) ? AW'(SHIFT_STEP) : {1'b0, rem_q};
    case (sop_q)
      OP_SLL:  step_val = work_q << step_amt;
      OP_SRA:  step_val = DATA_WIDTH'($signed(work_q) >>> step_amt);
      default: step_val = work_q >> step_amt;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    branch_d = branch_q;
    work_d   = work_q;
    rem_d    = rem_q;
    sop_d    = sop_q;

    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_SHIFT: begin
        work_d = step_val;
        rem_d  = rem_q - SHW'(step_amt);
        if (rem_q == SHW'(step_amt)) begin
          state_d  = ST_DONE;
          result_d = step_val;
          zero_d   = (step_val == '0);
          branch_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept only happens from IDLE or a DONE being drained, so it overrides the above.
    if (accept) begin
      if (start_shift) begin
        state_d = ST_SHIFT;
        work_d  = operand_a;
        rem_d   = shamt;
        sop_d   = operation;
      end else begin
        state_d  = ST_DONE;
        result_d = one_res;
        zero_d   = (one_res == '0);
        branch_d = one_br;
      end
    end

    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      branch_q <= 1'b0;
      work_q   <= '0;
      rem_q    <= '0;
      sop_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      branch_q <= branch_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      sop_q    <= sop_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model results on accept, monitor checks outputs.
module tb_alu_exec_unit;
  localparam int unsigned DW   = 32;
  localparam int unsigned STEP = 4;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BLT = 4'b1001;
  localparam logic [3:0] OP_BGE = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;
  localparam logic [3:0] OP_SLL = 4'b1100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    operation;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          zero;
  logic          branch_taken;

  alu_exec_unit #(.DATA_WIDTH(DW), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .operation(operation),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic          z;
    logic          br;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural reference: plain arithmetic straight from the op definitions.
  function automatic void model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [DW-1:0] r, output logic br, output int lat);
    int sh;
    sh  = int'(b % DW);
    r   = '0;
    br  = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  r = a >> sh;
      4'd6:  r = a - b;
      4'd7:  r = DW'($signed(a) >>> sh);
      4'd8:  br = (a == b);
      4'd9:  br = ($signed(a) < $signed(b));
      4'd10: br = !($signed(a) < $signed(b));
      4'd11: br = (a != b);
      4'd12: r = a << sh;
      default: r = '0;
    endcase
`ifndef ALU_EXEC_FAST_SHIFT_EN
    if ((op == 4'd5 || op == 4'd7 || op == 4'd12) && sh != 0)
      lat = 1 + (sh + int'(STEP) - 1) / int'(STEP);
`endif
  endfunction

  // One clock of stimulus; records expected response when the op is accepted.
  task automatic cycle(input bit v, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit ordy, input bit fl, output bit acc);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid = v; operation = op; operand_a = a; operand_b = b; out_ready = ordy; flush = fl;
    #1;
    acc = v && in_ready;
    if (acc) begin
      model(op, a, b, e.res, e.br, e.lat);
      e.z   = (e.res == '0);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit ordy);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 64 && !acc; n++) cycle(1'b1, op, a, b, ordy, 1'b0, acc);
    chk("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic idle(input bit ordy, output bit rdy);
    bit acc;
    cycle(1'b0, 4'd0, '0, '0, ordy, 1'b0, acc);
    rdy = in_ready;
  endtask

  task automatic drain();
    bit rdy;
    for (int n = 0; n < 200 && sb.size() != 0; n++) idle(1'b1, rdy);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every cycle compare out_valid against the model, and payload while valid.
  initial begin
    bit   exp_v;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        exp_v = (sb.size() != 0) && ((cyc - sb[0].acc) >= sb[0].lat);
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v && out_valid) begin
          e = sb[0];
          chk("result", 64'(result), 64'(e.res));
          chk("zero", 64'(zero), 64'(e.z));
          chk("branch_taken", 64'(branch_taken), 64'(e.br));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit rdy;
    int busy;
    logic [DW-1:0] ra, rb;
    logic [3:0]    rop;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    operation = '0; operand_a = '0; operand_b = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_branch", 64'(branch_taken), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    send(OP_SUB, 32'd5, 32'd5, 1'b1);
    drain();

    // Iterative SRA by 31: count cycles the unit is busy.
    send(OP_SRA, 32'h8000_0000, 32'd31, 1'b1);
    busy = 0;
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin
      idle(1'b1, rdy);
      if (!rdy) busy++;
    end
`ifdef ALU_EXEC_FAST_SHIFT_EN
    chk("sra_busy_cycles", 64'(busy), 64'd0);
`else
    chk("sra_busy_cycles", 64'(busy), 64'd8);
`endif
    send(OP_SRL, 32'h8000_0000, 32'd31, 1'b1);
    send(OP_SRA, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b1);
    send(OP_SLL, 32'd1, 32'd31, 1'b1);
    send(OP_BLT, 32'hFFFF_FFFF, 32'd1, 1'b1);
    send(OP_BGE, 32'hFFFF_FFFF, 32'd1, 1'b1);
    send(OP_BNE, 32'd3, 32'd3, 1'b1);
    send(OP_BEQ, 32'd3, 32'd3, 1'b1);
    send(4'hE, 32'h1234, 32'h5678, 1'b1);
    drain();

    // Hold in DONE for 3 cycles: new ops ignored, then a no-bubble accept.
    send(OP_ADD, 32'd10, 32'd20, 1'b0);
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, OP_OR, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, acc);
      chk("held_no_accept", 64'(acc), 64'd0);
    end
    cycle(1'b1, OP_XOR, 32'd6, 32'd3, 1'b1, 1'b0, acc);
    chk("no_bubble_accept", 64'(acc), 64'd1);
    drain();

    // Flush in the 3rd shift cycle of SLL 1 by 20.
    send(OP_SLL, 32'd1, 32'd20, 1'b0);
    idle(1'b0, rdy);
    idle(1'b0, rdy);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
    @(posedge clk); #1 sb.delete();
    idle(1'b0, rdy);
    chk("flush_idle_ready", 64'(rdy), 64'd1);
    cycle(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, 1'b1, acc);
    chk("flush_beats_accept", 64'(acc), 64'd0);
    for (int n = 0; n < 4; n++) idle(1'b1, rdy);

    // Asynchronous reset in the middle of a shift.
    send(OP_ADD, 32'd1, 32'd2, 1'b1);
    drain();
    send(OP_SLL, 32'd1, 32'd20, 1'b1);
    idle(1'b1, rdy);
    @(negedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    chk("midrst_branch", 64'(branch_taken), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    idle(1'b1, rdy);
    chk("midrst_in_ready", 64'(rdy), 64'd1);

    // Randomised traffic with random consumer back-pressure.
    for (int n = 0; n < 500; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 32'($urandom_range(0, 40));
        default: rb = $urandom;
      endcase
      cycle(($urandom_range(0, 3) != 0), rop, ra, rb, ($urandom_range(0, 3) != 0), 1'b0, acc);
    end
    drain();
    repeat (3) idle(1'b1, rdy);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
